// File: rtl/ila_capture_ctrl.sv
// Logic-analyzer capture controller: pre/post-trigger ring buffer with handshaked readout.
// Define ILA_QUAL_EN to enable per-sample storage qualification via probe_qual.
module ila_capture_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int PRE_TRIG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] probe,
  input  logic              probe_qual,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              start_read,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              armed,
  output logic              triggered,
  output logic              done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_READ = 3'd5;

  localparam logic [AW-1:0] PRE_N  = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_N = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [AW:0]   RD_N   = (AW+1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic [AW-1:0]     ra_q, ra_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic elig;
  logic match;
  logic we;
  logic rd_load;
  logic rd_hs;

`ifdef ILA_QUAL_EN
  assign elig = probe_qual;
`else
  logic unused_qual;
  assign unused_qual = probe_qual;
  assign elig = 1'b1;
`endif

  assign match = ((probe ^ trig_value) & trig_mask) == '0;
  assign rd_hs = rd_valid_q & rd_ready;

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    ra_d        = ra_q;
    rd_cnt_d    = rd_cnt_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    we          = 1'b0;
    rd_load     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_PRE;
          wp_d      = '0;
          pre_cnt_d = '0;
        end
      end
      S_PRE: begin
        if (elig) begin
          we   = 1'b1;
          wp_d = wp_q + 1'b1;
          if (pre_cnt_q != PRE_N) pre_cnt_d = pre_cnt_q + 1'b1;
        end
        if (PRE_TRIG == 0 || (elig && (pre_cnt_q + 1'b1) == PRE_N))
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (elig) begin
          we   = 1'b1;
          wp_d = wp_q + 1'b1;
          if (match) begin
            trig_addr_d = wp_q;
            post_cnt_d  = POST_N;
            state_d     = (POST_N == '0) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (elig) begin
          we         = 1'b1;
          wp_d       = wp_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_read) begin
          state_d  = S_READ;
          ra_d     = trig_addr_q - PRE_N;
          rd_cnt_d = '0;
        end
      end
      S_READ: begin
        // RAM output register doubles as the data register: fetch when empty or draining
        if ((!rd_valid_q || rd_ready) && rd_cnt_q != RD_N) begin
          rd_load    = 1'b1;
          ra_d       = ra_q + 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_cnt_q == RD_N - 1'b1);
        end else if (rd_hs) begin
          rd_valid_d = 1'b0;
        end
        if (rd_hs && rd_last_q) begin
          state_d    = S_IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      we         = 1'b0;
      rd_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      ra_q        <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      ra_q        <= ra_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      if (rd_load) rd_data_q <= mem[ra_q];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wp_q] <= probe;
  end

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;
  assign armed     = (state_q == S_PRE) || (state_q == S_WAIT) ||
                     (state_q == S_POST);
  assign triggered = (state_q == S_POST) || (state_q == S_DONE) ||
                     (state_q == S_READ);
  assign done      = (state_q == S_DONE) || (state_q == S_READ);

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Self-checking bench for ila_capture_ctrl (DATA_W=8, DEPTH=16, PRE_TRIG=4).
// Reference model: the capture is a window over the list of eligible samples.
module tb_ila_capture_ctrl;
  localparam int DW = 8;
  localparam int DL = 4;
  localparam int PT = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst, arm, abort, probe_qual, start_read, rd_ready;
  logic [DW-1:0] probe, trig_mask, trig_value;
  logic rd_valid, rd_last, armed, triggered, done;
  logic [DW-1:0] rd_data;

  int total = 0;
  int bad = 0;

  logic [7:0] stim_p[$];
  bit         stim_q[$];
  logic [7:0] exp_rd[$];
  int trig_i, fin_i;
  logic [7:0] got_first, got_last;

  ila_capture_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL), .PRE_TRIG(PT)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .probe(probe),
    .probe_qual(probe_qual), .trig_mask(trig_mask),
    .trig_value(trig_value), .start_read(start_read),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .armed(armed), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected capture = eligible samples [j-PT, j-PT+DEPTH), j = first match at index >= PT
  function automatic void model(input logic [7:0] m, input logic [7:0] v);
    logic [7:0] e[$];
    int idx[$];
    int j;
    bit found;
    exp_rd.delete();
    trig_i = -1;
    fin_i = -1;
    for (int i = 0; i < stim_p.size(); i++) begin
      bit el;
`ifdef ILA_QUAL_EN
      el = stim_q[i];
`else
      el = 1'b1;
`endif
      if (el) begin
        e.push_back(stim_p[i]);
        idx.push_back(i);
      end
    end
    found = 1'b0;
    j = PT;
    while (!found && j < e.size()) begin
      if ((e[j] & m) == (v & m)) found = 1'b1;
      else j++;
    end
    if (found && (j + DEPTH - PT - 1) < e.size()) begin
      trig_i = idx[j];
      fin_i = idx[j + DEPTH - PT - 1];
      for (int k = j - PT; k < j - PT + DEPTH; k++) exp_rd.push_back(e[k]);
    end
  endfunction

  task automatic build_counter(input int n, input bit even_only);
    stim_p.delete();
    stim_q.delete();
    for (int i = 0; i < n; i++) begin
      stim_p.push_back(i[7:0]);
      stim_q.push_back(even_only ? (i % 2 == 0) : 1'b1);
    end
  endtask

  task automatic capture(input string nm, input logic [7:0] m,
                         input logic [7:0] v);
    model(m, v);
    total++;
    if (fin_i < 0) begin
      bad++;
      $display("FAIL %s model: no complete capture in stimulus", nm);
    end
    trig_mask = m;
    trig_value = v;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    total++;
    if (armed !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s arm: armed=%b done=%b want 1 0", nm, armed, done);
    end
    for (int i = 0; i < stim_p.size(); i++) begin
      logic [2:0] want;
      probe = stim_p[i];
      probe_qual = stim_q[i];
      tick();
      want = {!(i >= fin_i), (i >= trig_i), (i >= fin_i)};
      total++;
      if ({armed, triggered, done} !== want) begin
        bad++;
        $display("FAIL %s flags@%0d: got %b want %b", nm, i,
                 {armed, triggered, done}, want);
      end
      if (i == fin_i) break;
    end
  endtask

  // mode 0: rd_ready held high, 1: toggling, 2: random
  task automatic readout(input string nm, input int mode);
    int k, first_v, last_c;
    bit stall;
    logic [7:0] pd;
    logic pl, rdy;
    k = 0;
    first_v = -1;
    last_c = -1;
    stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    for (int c = 0; c < 200 && k < DEPTH; c++) begin
      if (rd_valid && first_v < 0) first_v = c;
      if (stall) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl) begin
          bad++;
          $display("FAIL %s stall@%0d: got v=%b d=%h l=%b want 1 %h %b",
                   nm, c, rd_valid, rd_data, rd_last, pd, pl);
        end
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) :
            1'($urandom_range(0, 1));
      rd_ready = rdy;
      if (rd_valid && rdy) begin
        total++;
        if (rd_data !== exp_rd[k] || rd_last !== (k == DEPTH - 1)) begin
          bad++;
          $display("FAIL %s word%0d: got %h last=%b want %h last=%b", nm,
                   k, rd_data, rd_last, exp_rd[k], (k == DEPTH - 1));
        end
        if (k == 0) got_first = rd_data;
        got_last = rd_data;
        k++;
        last_c = c;
      end
      stall = rd_valid && !rdy;
      pd = rd_data;
      pl = rd_last;
      tick();
    end
    rd_ready = 1'b0;
    total++;
    if (k != DEPTH) begin
      bad++;
      $display("FAIL %s count: got %0d words want %0d", nm, k, DEPTH);
    end
    total++;
    if (first_v < 0 || first_v > 2) begin
      bad++;
      $display("FAIL %s latency: first valid cycle %0d want <=2", nm, first_v);
    end
    if (mode == 0) begin
      total++;
      if (last_c - first_v != DEPTH - 1) begin
        bad++;
        $display("FAIL %s gaps: span %0d want %0d", nm, last_c - first_v,
                 DEPTH - 1);
      end
    end
    total++;
    if ({armed, triggered, done, rd_valid} !== 4'b0) begin
      bad++;
      $display("FAIL %s idle: flags %b want 0000", nm,
               {armed, triggered, done, rd_valid});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({armed, triggered, done, rd_valid, rd_last} !== 5'b0 ||
        rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset: flags %b data %h want 00000 00",
               {armed, triggered, done, rd_valid, rd_last}, rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    build_counter(64, 1'b0);
    capture("trig0A", 8'hFF, 8'h0A);
    readout("trig0A", 0);
    total++;
    if (got_first !== 8'h06 || got_last !== 8'h15) begin
      bad++;
      $display("FAIL trig0A ends: got %h..%h want 06..15", got_first, got_last);
    end
    build_counter(300, 1'b0);
    capture("wrap02", 8'hFF, 8'h02);
    readout("wrap02", 0);
    total++;
    if (got_first !== 8'hFE || got_last !== 8'h0D) begin
      bad++;
      $display("FAIL wrap02 ends: got %h..%h want fe..0d", got_first, got_last);
    end
    build_counter(64, 1'b0);
    capture("mask0", 8'h00, 8'h5A);
    readout("mask0_toggle", 1);
    total++;
    if (got_first !== 8'h00 || got_last !== 8'h0F) begin
      bad++;
      $display("FAIL mask0 ends: got %h..%h want 00..0f", got_first, got_last);
    end
  endtask

  task automatic test_qual();
    logic [7:0] wf, wl;
`ifdef ILA_QUAL_EN
    wf = 8'h0C;
    wl = 8'h2A;
`else
    wf = 8'h10;
    wl = 8'h1F;
`endif
    build_counter(100, 1'b1);
    capture("qual14", 8'hFF, 8'h14);
    readout("qual14", 0);
    total++;
    if (got_first !== wf || got_last !== wl) begin
      bad++;
      $display("FAIL qual14 ends: got %h..%h want %h..%h", got_first,
               got_last, wf, wl);
    end
  endtask

  task automatic test_ignored_cmds();
    build_counter(64, 1'b0);
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL read_in_idle: valid=%b done=%b want 0 0", rd_valid, done);
    end
    capture("ign", 8'hFF, 8'h07);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    total++;
    if (armed !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL arm_in_done: armed=%b done=%b want 0 1", armed, done);
    end
    readout("ign", 2);
  endtask

  task automatic test_abort();
    trig_mask = 8'hFF;
    trig_value = 8'h0A;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 13; i++) begin
      probe = i[7:0];
      probe_qual = 1'b1;
      tick();
    end
    total++;
    if (triggered !== 1'b1 || armed !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: trig=%b armed=%b want 1 1", triggered, armed);
    end
    abort = 1'b1;
    arm = 1'b1;
    probe = 8'd13;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    total++;
    if ({armed, triggered, done, rd_valid} !== 4'b0) begin
      bad++;
      $display("FAIL abort: flags %b want 0000",
               {armed, triggered, done, rd_valid});
    end
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    tick();
    total++;
    if ({armed, done, rd_valid} !== 3'b0) begin
      bad++;
      $display("FAIL abort_after: flags %b want 000", {armed, done, rd_valid});
    end
  endtask

  task automatic test_reset_mid();
    build_counter(64, 1'b0);
    capture("rstmid", 8'hFF, 8'h09);
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({armed, triggered, done, rd_valid, rd_last} !== 5'b0 ||
        rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: flags %b data %h want 00000 00",
               {armed, triggered, done, rd_valid, rd_last}, rd_data);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      logic [7:0] m, v;
      int p;
      m = 8'($urandom) & 8'($urandom);
      v = 8'($urandom);
      p = $urandom_range(40, 80);
      stim_p.delete();
      stim_q.delete();
      for (int i = 0; i < 140; i++) begin
        stim_p.push_back(8'($urandom));
        stim_q.push_back((i < 8 || i >= 100) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      stim_p[p] = v;
      stim_q[p] = 1'b1;
      capture($sformatf("rand%0d", r), m, v);
      readout($sformatf("rand%0d", r), 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    probe = '0;
    probe_qual = 1'b0;
    trig_mask = '0;
    trig_value = '0;
    start_read = 1'b0;
    rd_ready = 1'b0;
    got_first = '0;
    got_last = '0;
    test_reset();
    test_directed();
    test_qual();
    test_ignored_cmds();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ila_capture_ctrl.md
ILA_CAPTURE_CTRL -- requirements
Module: ila_capture_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: probe/sample width in bits.
REQ-002 Parameter DEPTH_LOG2, default 8: capture buffer holds DEPTH = 2**DEPTH_LOG2 samples.
REQ-003 Parameter PRE_TRIG, default 16: pre-trigger sample count; legal range 0..DEPTH-1.
REQ-004 clk  in  1: single clock for all logic.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 arm  in  1: one-cycle start-capture pulse.
REQ-007 abort  in  1: return to IDLE from any state.
REQ-008 probe  in  DATA_W: sample data, sampled every clk.
REQ-009 probe_qual  in  1: storage qualifier; used only under ILA_QUAL_EN.
REQ-010 trig_mask  in  DATA_W: trigger compare mask; 1 = bit compared.
REQ-011 trig_value  in  DATA_W: trigger compare value.
REQ-012 start_read  in  1: one-cycle pulse that begins readout.
REQ-013 rd_valid  out  1; rd_ready  in  1: readout handshake.
REQ-014 rd_data  out  DATA_W: readout sample; rd_last  out  1: final sample flag.
REQ-015 armed, triggered, done  out  1 each: status flags.

Function
REQ-016 States IDLE, PRE, WAIT_TRIG, POST, DONE, READ; internal DEPTH x DATA_W RAM, synchronous read, circular write pointer wp.
REQ-017 IDLE: arm=1 -> PRE next cycle; wp and pre_cnt cleared; armed=1 from PRE through POST.
REQ-018 PRE/WAIT_TRIG/POST: each eligible sample written to RAM[wp], wp increments mod DEPTH (wrap from DEPTH-1 to 0).
REQ-019 PRE: pre_cnt counts eligible samples, saturating; PRE -> WAIT_TRIG once pre_cnt reaches PRE_TRIG (PRE_TRIG=0: WAIT_TRIG after first cycle).
REQ-020 Trigger match: (probe & trig_mask) == (trig_value & trig_mask), evaluated only in WAIT_TRIG on eligible samples; matches in PRE ignored.
REQ-021 On match: trigger sample stored, trig_addr = wp, triggered=1, state -> POST, post_cnt loaded with DEPTH-PRE_TRIG-1.
REQ-022 POST: post_cnt decrements per stored sample; storing the sample that takes it to 0 -> DONE; DEPTH-PRE_TRIG-1 = 0 -> DONE immediately after trigger.
REQ-023 DONE: done=1, no writes; start_read -> READ; arm ignored.
REQ-024 READ: exactly DEPTH samples, oldest first, start address (trig_addr - PRE_TRIG) mod DEPTH; rd_valid first asserts at most 2 cycles after READ entry.
REQ-025 rd_data/rd_last held stable while rd_valid=1 and rd_ready=0; next word presented the cycle after handshake when prefetched; no gaps under continuous rd_ready.
REQ-026 rd_last=1 only with the DEPTH-th word; its handshake -> IDLE, done and triggered cleared.
REQ-027 arm outside IDLE ignored; start_read outside DONE ignored.
REQ-028 abort=1 in any state -> IDLE next cycle, all flags and rd_valid cleared; abort wins over simultaneous arm/start_read.

Reset
REQ-029 rst=1 forces IDLE asynchronously; armed, triggered, done, rd_valid, rd_last = 0; rd_data = 0; wp, pre_cnt, post_cnt, trig_addr = 0.
REQ-030 Reset mid-capture or mid-readout discards the capture; RAM contents not reset.

Configuration
REQ-031 Macro ILA_QUAL_EN defined: sample eligible only when probe_qual=1; non-eligible cycles neither write, count, nor trigger.
REQ-032 ILA_QUAL_EN undefined: every cycle eligible; probe_qual port present and ignored.

Verification (DATA_W=8, DEPTH_LOG2=4, PRE_TRIG=4; probe = 8-bit counter, 0x00 on first PRE cycle)
REQ-033 arm, mask=0xFF, value=0x0A -> trigger on 0x0A; readout 0x06..0x15, rd_last with 0x15, then IDLE.
REQ-034 mask=0xFF, value=0x02 -> 0x02 ignored (in PRE); trigger on wrap at 0x02 of next lap; readout 0xFE,0xFF,0x00..0x0D.
REQ-035 mask=0x00 -> trigger on first WAIT_TRIG sample 0x04; readout 0x00..0x0F.
REQ-036 readout with rd_ready toggling 1/0 each cycle -> same 16 words in order, rd_data stable during stall cycles.
REQ-037 abort asserted 3 cycles into POST together with arm -> IDLE next cycle, armed=triggered=done=0, no readout.
REQ-038 ILA_QUAL_EN, probe_qual=1 on even counter values only, value=0x14 -> readout 0x0C,0x0E,...,0x2A (16 even values).
